// File: rtl/fifo_pkg.sv
// Shared constants and parameter legality helpers for the synchronous FIFO family.
package fifo_pkg;

    // Read-port modes: registered (standard) or first-word-fall-through
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Almost-full threshold must lie in 1..DEPTH
    function automatic bit fifo_af_ok(input int depth, input int af_thresh);
        return (af_thresh >= 1) && (af_thresh <= depth);
    endfunction

    // Almost-empty threshold must lie in 0..DEPTH-1
    function automatic bit fifo_ae_ok(input int depth, input int ae_thresh);
        return (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

    // Combined check used by every FIFO top, including depth and mode
    function automatic bit fifo_params_ok(input int depth, input int af_thresh,
                                          input int ae_thresh, input int mode);
        return (depth >= 2) && fifo_af_ok(depth, af_thresh) && fifo_ae_ok(depth, ae_thresh)
               && ((mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT));
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write port, asynchronous read port, no reset.
module fifo_mem_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// selectable standard or first-word-fall-through read, synchronous flush
// and registered overflow/underflow pulses.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almost_empty_o,
    output logic             almost_full_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!fifo_params_ok(DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
        $error("sync_fifo_fwft: illegal DEPTH/AF_THRESH/AE_THRESH/FWFT combination");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             empty_r;
    logic             full_r;
    logic             ae_r;
    logic             af_r;
    logic             ov_r;
    logic             un_r;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Pointer advance with explicit wrap so non-power-of-two depths work
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Accept decisions and the occupancy the FIFO will have after this edge
    always_comb begin
        rd_acc     = rd_en_i & ~empty_r;
        wr_acc     = wr_en_i & (~full_r | rd_acc);
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers, count, status flags and error pulses; flush overrides traffic
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ae_r    <= 1'b1;
            af_r    <= 1'b0;
            ov_r    <= 1'b0;
            un_r    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ae_r    <= 1'b1;
            af_r    <= 1'b0;
            ov_r    <= 1'b0;
            un_r    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count   <= count_next;
            empty_r <= (count_next == '0);
            full_r  <= (count_next == CW'(DEPTH));
            ae_r    <= (count_next <= CW'(AE_THRESH));
            af_r    <= (count_next >= CW'(AF_THRESH));
            ov_r    <= wr_en_i & ~wr_acc;
            un_r    <= rd_en_i & ~rd_acc;
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk_i),
        .we    (wr_acc & ~flush_i),
        .waddr (wr_ptr),
        .wdata (wdata_i),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rdata_o = mem_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_r;

        // Capture the head word on an accepted pop; hold otherwise and across flush
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rdata_r <= '0;
            end else if (!flush_i && rd_acc) begin
                rdata_r <= mem_rdata;
            end
        end

        assign rdata_o = rdata_r;
    end

    assign empty_o        = empty_r;
    assign full_o         = full_r;
    assign almost_empty_o = ae_r;
    assign almost_full_o  = af_r;
    assign count_o        = count;
    assign overflow_o     = ov_r;
    assign underflow_o    = un_r;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: a directed vector table on a
// DEPTH=16 standard-read instance, plus hand sequences for flush, reset,
// pointer wrap on DEPTH=5 and first-word-fall-through on DEPTH=4.
module tb_sync_fifo_fwft;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Instance A: DEPTH=16, standard read
    logic       a_flush = 0, a_wr = 0, a_rd = 0;
    logic [7:0] a_wdata = 0, a_rdata;
    logic       a_empty, a_full, a_ae, a_af, a_ov, a_un;
    logic [4:0] a_count;

    sync_fifo_fwft #(.DEPTH(16), .WIDTH(8), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(a_flush), .wr_en_i(a_wr), .wdata_i(a_wdata),
        .rd_en_i(a_rd), .rdata_o(a_rdata), .empty_o(a_empty), .full_o(a_full),
        .almost_empty_o(a_ae), .almost_full_o(a_af), .count_o(a_count),
        .overflow_o(a_ov), .underflow_o(a_un));

    // Instance B: DEPTH=5 (non power of two), standard read
    logic       b_flush = 0, b_wr = 0, b_rd = 0;
    logic [7:0] b_wdata = 0, b_rdata;
    logic       b_empty, b_full, b_ae, b_af, b_ov, b_un;
    logic [2:0] b_count;

    sync_fifo_fwft #(.DEPTH(5), .WIDTH(8), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(b_flush), .wr_en_i(b_wr), .wdata_i(b_wdata),
        .rd_en_i(b_rd), .rdata_o(b_rdata), .empty_o(b_empty), .full_o(b_full),
        .almost_empty_o(b_ae), .almost_full_o(b_af), .count_o(b_count),
        .overflow_o(b_ov), .underflow_o(b_un));

    // Instance C: DEPTH=4, first-word-fall-through
    logic       c_flush = 0, c_wr = 0, c_rd = 0;
    logic [7:0] c_wdata = 0, c_rdata;
    logic       c_empty, c_full, c_ae, c_af, c_ov, c_un;
    logic [2:0] c_count;

    sync_fifo_fwft #(.DEPTH(4), .WIDTH(8), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(c_flush), .wr_en_i(c_wr), .wdata_i(c_wdata),
        .rd_en_i(c_rd), .rdata_o(c_rdata), .empty_o(c_empty), .full_o(c_full),
        .almost_empty_o(c_ae), .almost_full_o(c_af), .count_o(c_count),
        .overflow_o(c_ov), .underflow_o(c_un));

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [7:0] rdata;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
        logic       ov;
        logic       un;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] wd,
                                input logic [7:0] rdata, input int cnt,
                                input logic ov, input logic un);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wd = wd; v.rdata = rdata; v.cnt = 5'(cnt);
        v.emp = (cnt == 0); v.ful = (cnt == 16);
        v.ae = (cnt <= 2); v.af = (cnt >= 12);
        v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_a();
        return {13'd0, a_rdata, a_count, a_empty, a_full, a_ae, a_af, a_ov, a_un};
    endfunction

    initial begin
        // Vector table: fill, overflow, simultaneous at full, drain, underflow, simultaneous at empty
        for (int i = 0; i < 16; i++) vecs[i] = mk(1, 0, 8'(i), 8'h00, i + 1, 0, 0);
        vecs[16] = mk(1, 0, 8'hEE, 8'h00, 16, 1, 0);
        vecs[17] = mk(1, 1, 8'h55, 8'h00, 16, 0, 0);
        for (int j = 0; j < 16; j++)
            vecs[18 + j] = mk(0, 1, 8'h00, (j < 15) ? 8'(j + 1) : 8'h55, 15 - j, 0, 0);
        vecs[34] = mk(0, 1, 8'h00, 8'h55, 0, 0, 1);
        vecs[35] = mk(1, 1, 8'h33, 8'h55, 1, 0, 1);
        vecs[36] = mk(0, 1, 8'h00, 8'h33, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("a reset state", pack_a(), {13'd0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            a_wr = vecs[i].wr; a_rd = vecs[i].rd; a_wdata = vecs[i].wd;
            tick();
            check_val($sformatf("a row %0d", i), pack_a(),
                      {13'd0, vecs[i].rdata, vecs[i].cnt, vecs[i].emp, vecs[i].ful,
                       vecs[i].ae, vecs[i].af, vecs[i].ov, vecs[i].un});
        end
        a_wr = 0; a_rd = 0;

        // Flush with count 9 while also requesting read and write
        for (int i = 0; i < 9; i++) begin
            a_wr = 1; a_wdata = 8'h40 + 8'(i);
            tick();
        end
        a_wr = 0;
        check_val("a count before flush", 32'(a_count), 32'd9);
        a_flush = 1; a_wr = 1; a_rd = 1; a_wdata = 8'hBB;
        tick();
        a_flush = 0; a_wr = 0; a_rd = 0;
        check_val("a after flush", pack_a(), {13'd0, 8'h33, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        a_wr = 1; a_wdata = 8'h99;
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        check_val("a read after flush", 32'(a_rdata), 32'h99);

        // DEPTH=5 wrap: prime 3 words, then 9 simultaneous write/read, then drain
        for (int i = 0; i < 3; i++) begin
            b_wr = 1; b_wdata = 8'hA0 + 8'(i);
            tick();
        end
        for (int k = 0; k < 9; k++) begin
            b_wr = 1; b_rd = 1; b_wdata = 8'hA3 + 8'(k);
            tick();
            check_val($sformatf("b wrap data %0d", k), 32'(b_rdata), 32'hA0 + 32'(k));
            check_val($sformatf("b wrap flags %0d", k),
                      {26'd0, b_count, b_empty, b_full, b_ov}, {26'd0, 3'd3, 1'b0, 1'b0, 1'b0});
        end
        b_wr = 0;
        for (int k = 0; k < 3; k++) begin
            b_rd = 1;
            tick();
            check_val($sformatf("b drain %0d", k), {21'd0, b_rdata, b_count},
                      {21'd0, 8'hA9 + 8'(k), 3'(2 - k)});
        end
        b_rd = 0;
        check_val("b empty after drain", {30'd0, b_empty, b_un}, {30'd0, 1'b1, 1'b0});

        // FWFT: written word appears on rdata without a read, pop exposes the next
        c_wr = 1; c_wdata = 8'h7E;
        tick();
        c_wr = 0;
        check_val("c fwft head", {23'd0, c_empty, c_rdata}, {23'd0, 1'b0, 8'h7E});
        c_wr = 1; c_wdata = 8'h11;
        tick();
        c_wr = 0;
        check_val("c fwft head holds", {20'd0, c_count, c_rdata}, {20'd0, 3'd2, 8'h7E});
        c_rd = 1;
        tick();
        check_val("c fwft pop 1", {20'd0, c_count, c_rdata}, {20'd0, 3'd1, 8'h11});
        tick();
        c_rd = 0;
        check_val("c fwft pop 2", {29'd0, c_empty, c_count}, {29'd0, 1'b1, 3'd0});

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            a_wr = 1; a_wdata = 8'h61 + 8'(i);
            tick();
        end
        a_wr = 0; a_rd = 1;
        tick();
        a_wr = 1; a_rd = 0; a_wdata = 8'h77;
        check_val("a before reset", 32'(a_rdata), 32'h61);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("a async reset", pack_a(), {13'd0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        a_wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        a_rd = 1;
        tick();
        a_rd = 0;
        check_val("a underflow after reset", {26'd0, a_count, a_un}, {26'd0, 5'd0, 1'b1});
        tick();
        check_val("a underflow pulse ends", 32'(a_un), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
